// File: rtl/player_move_ctrl.sv
// Player grid movement: press-immediate stepping with timed auto-repeat, bounded to the grid.
// Define PLAYER_MOVE_WRAP_EN to wrap at grid edges instead of saturating (hit_wall then stays 0).
module player_move_ctrl #(
  parameter int TICK_DIV      = 2500000,
  parameter int FIRST_DELAY   = 8,
  parameter int REPEAT_PERIOD = 4,
  parameter int GRID_W        = 20,
  parameter int GRID_H        = 15,
  parameter int COORD_W       = 5,
  parameter int X_INIT        = 10,
  parameter int Y_INIT        = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         nums,
  input  logic               enable,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic [1:0]         dir,
  output logic               moved,
  output logic               hit_wall
);

  localparam int DLY_MAX = (FIRST_DELAY > REPEAT_PERIOD) ? FIRST_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(DLY_MAX + 1);
  localparam int PRE_W   = $clog2(TICK_DIV);

  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(GRID_H - 1);

  // Axis velocity encoding: 00 none, 01 plus one, 11 minus one.
  localparam logic [1:0] V_NONE  = 2'b00;
  localparam logic [1:0] V_PLUS  = 2'b01;
  localparam logic [1:0] V_MINUS = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    HOLD_FIRST,
    HOLD_REPEAT
  } state_t;

  state_t             state;
  logic [PRE_W-1:0]   prescale;
  logic               tick;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         vx;
  logic [1:0]         vy;
  logic [3:0]         vec;
  logic [3:0]         vec_q;
  logic               new_press;
  logic               step_now;
  logic [COORD_W-1:0] next_x;
  logic [COORD_W-1:0] next_y;
  logic               x_blocked;
  logic               y_blocked;
  logic               step_moved;
  logic               step_hit;
  logic [1:0]         step_dir;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescale <= '0;
    end else if (prescale == PRE_W'(TICK_DIV - 1)) begin
      prescale <= '0;
    end else begin
      prescale <= prescale + 1'b1;
    end
  end

  assign tick = (prescale == PRE_W'(TICK_DIV - 1));

  always_comb begin
    vx = V_NONE;
    vy = V_NONE;
    if (nums[1] && !nums[0]) vx = V_MINUS;
    else if (nums[0] && !nums[1]) vx = V_PLUS;
    if (nums[3] && !nums[2]) vy = V_MINUS;
    else if (nums[2] && !nums[3]) vy = V_PLUS;
  end

  assign vec       = {vx, vy};
  assign new_press = (vec != 4'd0) && (vec != vec_q);
  // The counter holds 1 on the tick that brings it to zero, so that tick carries the repeat step.
  assign step_now  = enable && (new_press ||
                     ((state != IDLE) && (vec != 4'd0) && (vec == vec_q) && tick && (cnt == CNT_W'(1))));

  always_comb begin
    next_x    = pos_x;
    next_y    = pos_y;
    x_blocked = 1'b0;
    y_blocked = 1'b0;
    case (vx)
      V_PLUS: begin
        if (pos_x == X_MAX) begin
`ifdef PLAYER_MOVE_WRAP_EN
          next_x = '0;
`else
          x_blocked = 1'b1;
`endif
        end else begin
          next_x = pos_x + 1'b1;
        end
      end
      V_MINUS: begin
        if (pos_x == '0) begin
`ifdef PLAYER_MOVE_WRAP_EN
          next_x = X_MAX;
`else
          x_blocked = 1'b1;
`endif
        end else begin
          next_x = pos_x - 1'b1;
        end
      end
      default: ;
    endcase
    case (vy)
      V_PLUS: begin
        if (pos_y == Y_MAX) begin
`ifdef PLAYER_MOVE_WRAP_EN
          next_y = '0;
`else
          y_blocked = 1'b1;
`endif
        end else begin
          next_y = pos_y + 1'b1;
        end
      end
      V_MINUS: begin
        if (pos_y == '0) begin
`ifdef PLAYER_MOVE_WRAP_EN
          next_y = Y_MAX;
`else
          y_blocked = 1'b1;
`endif
        end else begin
          next_y = pos_y - 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign step_moved = (next_x != pos_x) || (next_y != pos_y);
  assign step_hit   = x_blocked || y_blocked;

  // Horizontal intent dominates the facing direction whenever it is present.
  always_comb begin
    step_dir = 2'b00;
    if (vx == V_PLUS) step_dir = 2'b11;
    else if (vx == V_MINUS) step_dir = 2'b10;
    else if (vy == V_PLUS) step_dir = 2'b01;
    else step_dir = 2'b00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      vec_q    <= '0;
      pos_x    <= COORD_W'(X_INIT);
      pos_y    <= COORD_W'(Y_INIT);
      dir      <= 2'b00;
      moved    <= 1'b0;
      hit_wall <= 1'b0;
    end else begin
      vec_q    <= enable ? vec : 4'd0;
      moved    <= 1'b0;
      hit_wall <= 1'b0;

      if (!enable) begin
        state <= IDLE;
        cnt   <= '0;
      end else if (new_press) begin
        state <= HOLD_FIRST;
        cnt   <= CNT_W'(FIRST_DELAY);
      end else if (vec == 4'd0) begin
        state <= IDLE;
        cnt   <= '0;
      end else if ((state != IDLE) && tick) begin
        if (cnt == CNT_W'(1)) begin
          state <= HOLD_REPEAT;
          cnt   <= CNT_W'(REPEAT_PERIOD);
        end else begin
          cnt <= cnt - 1'b1;
        end
      end

      if (step_now) begin
        pos_x    <= next_x;
        pos_y    <= next_y;
        dir      <= step_dir;
        moved    <= step_moved;
        hit_wall <= step_hit;
      end
    end
  end

endmodule

// File: tb/tb_player_move_ctrl.sv
// Randomized and directed bench for player_move_ctrl against a tick-counting behavioural model.
module tb_player_move_ctrl;

  localparam int TD = 4;
  localparam int FD = 3;
  localparam int RP = 2;
  localparam int GW = 8;
  localparam int GH = 8;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    nums = 4'd0;
  logic          enable = 1'b1;
  logic [CW-1:0] pos_x;
  logic [CW-1:0] pos_y;
  logic [1:0]    dir;
  logic          moved;
  logic          hit_wall;

  int assertions = 0;
  int failures = 0;

  // Model state: position, strobes, previous resolved vector, ticks since the press.
  int mx, my, mdir, mmoved, mhit;
  int pvx, pvy, holding, holdTicks, k;

  player_move_ctrl #(
    .TICK_DIV(TD), .FIRST_DELAY(FD), .REPEAT_PERIOD(RP),
    .GRID_W(GW), .GRID_H(GH), .COORD_W(CW), .X_INIT(4), .Y_INIT(4)
  ) dut (
    .clk(clk), .rst(rst), .nums(nums), .enable(enable),
    .pos_x(pos_x), .pos_y(pos_y), .dir(dir), .moved(moved), .hit_wall(hit_wall)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    assertions++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] n, input logic e, input int cycles);
    @(negedge clk);
    nums = n;
    enable = e;
    repeat (cycles) @(posedge clk);
    #2;
  endtask

  task automatic resetModel();
    mx = 4; my = 4; mdir = 0; mmoved = 0; mhit = 0;
    pvx = 0; pvy = 0; holding = 0; holdTicks = 0; k = 0;
  endtask

  // Steps happen on the press edge, then FD ticks later, then every RP ticks.
  task automatic updateModel();
    int vx, vy, tx, ty, step, tickNow;
    vx = (nums[1] && !nums[0]) ? -1 : ((nums[0] && !nums[1]) ? 1 : 0);
    vy = (nums[3] && !nums[2]) ? -1 : ((nums[2] && !nums[3]) ? 1 : 0);
    if (!enable) begin vx = 0; vy = 0; end
    tickNow = ((k % TD) == TD - 1) ? 1 : 0;
    k++;
    step = 0;
    if (!enable) holding = 0;
    else if ((vx != 0 || vy != 0) && (vx != pvx || vy != pvy)) begin
      step = 1; holding = 1; holdTicks = 0;
    end else if (vx == 0 && vy == 0) holding = 0;
    else if (holding != 0 && tickNow != 0) begin
      holdTicks++;
      if (holdTicks >= FD && ((holdTicks - FD) % RP) == 0) step = 1;
    end
    mmoved = 0;
    mhit = 0;
    if (step != 0) begin
      tx = mx + vx;
      ty = my + vy;
`ifdef PLAYER_MOVE_WRAP_EN
      tx = (tx + GW) % GW;
      ty = (ty + GH) % GH;
`else
      if (tx < 0 || tx >= GW) begin mhit = 1; tx = mx; end
      if (ty < 0 || ty >= GH) begin mhit = 1; ty = my; end
`endif
      mmoved = (tx != mx || ty != my) ? 1 : 0;
      mx = tx;
      my = ty;
      mdir = (vx > 0) ? 3 : ((vx < 0) ? 2 : ((vy > 0) ? 1 : 0));
    end
    pvx = vx;
    pvy = vy;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      resetModel();
    end else begin
      updateModel();
      #1;
      if (!rst) begin
        checkOutput("model pos_x", int'(pos_x), mx);
        checkOutput("model pos_y", int'(pos_y), my);
        checkOutput("model dir", int'(dir), mdir);
        checkOutput("model moved", int'(moved), mmoved);
        checkOutput("model hit_wall", int'(hit_wall), mhit);
      end
    end
  end

  initial begin
    resetModel();
    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset pos_x", int'(pos_x), 4);
    checkOutput("reset pos_y", int'(pos_y), 4);
    checkOutput("reset dir", int'(dir), 0);
    checkOutput("reset moved", int'(moved), 0);
    checkOutput("reset hit_wall", int'(hit_wall), 0);
    @(negedge clk);
    rst = 1'b0;

`ifndef PLAYER_MOVE_WRAP_EN
    applyStimulus(4'b0001, 1'b1, 1);
    checkOutput("tap right x", int'(pos_x), 5);
    checkOutput("tap right moved", int'(moved), 1);
    checkOutput("tap right dir", int'(dir), 3);
    applyStimulus(4'b0000, 1'b1, 50);
    checkOutput("tap no repeat x", int'(pos_x), 5);

    applyStimulus(4'b0010, 1'b1, 1);
    checkOutput("left press x", int'(pos_x), 4);
    applyStimulus(4'b0010, 1'b1, 59);
    checkOutput("left held x", int'(pos_x), 0);
    checkOutput("left held moved", int'(moved), 0);

    applyStimulus(4'b1100, 1'b1, 20);
    checkOutput("cancel y", int'(pos_y), 4);
    applyStimulus(4'b1000, 1'b1, 1);
    checkOutput("vec change y", int'(pos_y), 3);
    checkOutput("vec change dir", int'(dir), 0);

    applyStimulus(4'b0000, 1'b1, 5);
    applyStimulus(4'b1001, 1'b1, 1);
    checkOutput("diag x", int'(pos_x), 1);
    checkOutput("diag y", int'(pos_y), 2);
    checkOutput("diag dir", int'(dir), 3);
    applyStimulus(4'b1001, 1'b0, 20);
    checkOutput("disabled x", int'(pos_x), 1);
    applyStimulus(4'b1001, 1'b1, 1);
    checkOutput("reenable x", int'(pos_x), 2);
    checkOutput("reenable y", int'(pos_y), 1);

    applyStimulus(4'b0101, 1'b1, 120);
    checkOutput("corner x", int'(pos_x), 7);
    checkOutput("corner y", int'(pos_y), 7);

    applyStimulus(4'b0001, 1'b1, 10);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("async rst x", int'(pos_x), 4);
    checkOutput("async rst y", int'(pos_y), 4);
    checkOutput("async rst dir", int'(dir), 0);
    checkOutput("async rst moved", int'(moved), 0);
    checkOutput("async rst hit", int'(hit_wall), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #2;
    checkOutput("held after rst x", int'(pos_x), 5);
    checkOutput("held after rst moved", int'(moved), 1);
`else
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'b0001, 1'b1, 1);
      applyStimulus(4'b0000, 1'b1, 2);
    end
    checkOutput("wrap x", int'(pos_x), 0);
`endif

    for (int seg = 0; seg < 80; seg++) begin
      if ($urandom_range(0, 19) == 0) begin
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      applyStimulus(4'($urandom_range(0, 15)), ($urandom_range(0, 9) != 0), $urandom_range(1, 40));
    end

    repeat (3) @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/player_move_ctrl.md
Name: player_move_ctrl

Overview:
- Consumes the 4-bit held-arrow-key vector from the keyboard signal decoder: bit3 up, bit2 down, bit1 left, bit0 right.
- Converts it into a bounded grid position for the player sprite, using press-immediate stepping plus timed auto-repeat.
- Feeds the game-logic and VGA render stages, which read pos_x/pos_y and the one-cycle moved/hit_wall strobes.

Parameters:
- TICK_DIV, 2500000: clk cycles per movement tick (40 Hz at 100 MHz); must be >= 2.
- FIRST_DELAY, 8: ticks from the initial press step to the first auto-repeat step; must be >= 1.
- REPEAT_PERIOD, 4: ticks between subsequent auto-repeat steps; must be >= 1.
- GRID_W, 20: grid columns; x range is 0..GRID_W-1.
- GRID_H, 15: grid rows; y range is 0..GRID_H-1.
- COORD_W, 5: coordinate width; requires 2^COORD_W >= max(GRID_W, GRID_H).
- X_INIT, 10: reset x position.
- Y_INIT, 7: reset y position.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous, active-high reset.
- nums, input, 4: held keys {up, down, left, right}, synchronous to clk.
- enable, input, 1: movement enable; low freezes the player.
- pos_x, output, COORD_W: current column.
- pos_y, output, COORD_W: current row (0 = top).
- dir, output, 2: last facing direction; 00 up, 01 down, 10 left, 11 right.
- moved, output, 1: one-cycle pulse when pos_x or pos_y changed.
- hit_wall, output, 1: one-cycle pulse when a step was blocked by the grid edge.

Behaviour:
- Reset values: pos_x=X_INIT, pos_y=Y_INIT, dir=00, moved=0, hit_wall=0, prescaler=0, tick counter=0, FSM=IDLE, registered vector vec_q=0.
- Axis resolution (combinational):
  - vy = -1 if up&~down, +1 if down&~up, else 0.
  - vx = -1 if left&~right, +1 if right&~left, else 0.
  - Opposite keys cancel on that axis only.
  - vec = {vx, vy}; vec_q is vec registered every cycle (forced to 0 while enable=0).
- Prescaler: free-running 0..TICK_DIV-1. tick is a 1-cycle pulse when the count equals TICK_DIV-1. It is unaffected by FSM state and enable.
- FSM states: IDLE, HOLD_FIRST, HOLD_REPEAT.
  - Any state, enable=0: go to IDLE, no step, counter=0.
  - Any state, vec != 0 and vec != vec_q (new press or direction change): step now, load counter=FIRST_DELAY, go to HOLD_FIRST.
  - Any state, vec = 0: go to IDLE, counter=0.
  - HOLD_FIRST/HOLD_REPEAT, vec == vec_q, tick: decrement counter. When the counter reaches 0 on this tick, step, reload REPEAT_PERIOD, go to HOLD_REPEAT.
- Step: apply vx to x and vy to y on the same edge. Diagonal moves are one combined step.
- Latency: nums changes before edge n; the new pos appears after edge n, and moved is high during the following cycle.
- Bounds (default build): each axis saturates at 0 and GRID-1. If any axis of a step is blocked, hit_wall=1 for that cycle. The other axis still moves if legal. moved=1 only if at least one coordinate changed; both strobes may be high together.
- dir updates on every step attempt, even a blocked one. Horizontal wins when vx != 0: 10 or 11; otherwise vertical: 00 or 01.
- Reset mid-hold: everything returns to reset values. Keys still held after rst deasserts count as a new press, because vec_q=0, so the first step occurs on the first clk edge after deassert.
- Raising enable with keys held is also a new press.

Optional Feature:
- Macro: PLAYER_MOVE_WRAP_EN.
- Defined: a step past an edge wraps (x=GRID_W-1 going right becomes 0; y=0 going up becomes GRID_H-1). moved=1, and hit_wall is tied to 0.
- Undefined: saturation and hit_wall behave as described under Behaviour.

Test Plan (TICK_DIV=4, FIRST_DELAY=3, REPEAT_PERIOD=2, GRID 8x8, init 4,4):
- Assert rst mid-run -> pos=(4,4), dir=00, moved=0, hit_wall=0 asynchronously, with no clock needed.
- nums=0001 for 1 cycle -> pos_x=5 one edge later, single moved pulse, dir=11, no further steps over 50 cycles.
- nums=0010 held for 60 cycles -> x=3 immediately, x=2 on the 3rd tick, x=1 and x=0 every 2 ticks thereafter, then hit_wall pulses every 2 ticks with x stuck at 0 and moved=0.
- nums=1100 held -> no movement, no strobes. Then nums=1000 -> y=3 on the next edge (a vector change counts as a new press).
- nums=1001 -> x=5 and y=3 on the same edge, single moved pulse, dir=11. Drop enable while held -> steps stop; restore enable -> immediate step to (6,2).
- With PLAYER_MOVE_WRAP_EN, from x=7 press right -> x=0, moved=1, hit_wall=0.
